// File: rtl/tisc_wb_regs.sv
// ---------------------------------------------------------------------------
// tisc_wb_regs
//   WISHBONE register slave for the 6-bit TISC master port. Holds the board
//   identity/version words, a CONTROL and a SCRATCH register with byte-lane
//   writes, a write-to-pulse strobe register, a two-flop synchronized status
//   readback and a saturating event counter with a latch.
//   Every access is a registered single beat: the response (ack_o or err_o)
//   appears one cycle after the strobe and stays high for exactly one cycle.
//
//   Optional feature macro: TISC_WB_REGS_ERR_EN
//     defined   : accesses to unmapped offsets (0x20-0x3C) answer with err_o
//                 and have no side effects.
//     undefined : unmapped accesses are acked, read 0, writes ignored, and
//                 err_o is tied 0.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i    WB cycle / strobe / write enable
//   adr_i[5:0]            byte address, [5:2] selects the word
//   dat_i[31:0], sel_i    write data and byte lane selects
//   dat_o, ack_o, err_o   read data, acknowledge, error
//   rty_o                 retry, always 0
//   ctrl_o[31:0]          CONTROL register contents
//   pulse_o[NPULSE-1:0]   single-cycle strobes written through PULSE
//   status_i[31:0]        asynchronous status bits
//   evt_i                 event level, synchronous to clk_i
// ---------------------------------------------------------------------------
module tisc_wb_regs #(
  parameter logic [31:0] IDENT     = 32'h54495343,
  parameter logic [31:0] VERSION   = 32'h00010000,
  parameter logic [31:0] CTRL_INIT = 32'h00000000,
  parameter int          NPULSE    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [5:0]        adr_i,
  input  logic [31:0]       dat_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o,
  output logic [31:0]       ctrl_o,
  output logic [NPULSE-1:0] pulse_o,
  input  logic [31:0]       status_i,
  input  logic              evt_i
);

  localparam logic [3:0] W_ID      = 4'd0;
  localparam logic [3:0] W_VERSION = 4'd1;
  localparam logic [3:0] W_CTRL    = 4'd2;
  localparam logic [3:0] W_PULSE   = 4'd3;
  localparam logic [3:0] W_STATUS  = 4'd4;
  localparam logic [3:0] W_COUNT   = 4'd5;
  localparam logic [3:0] W_LATCH   = 4'd6;
  localparam logic [3:0] W_SCRATCH = 4'd7;

  logic [3:0]  word;
  logic        access;
  logic        mapped;
  logic        commit;
  logic        wr;
  logic        rd;
  logic [31:0] rd_data;

  logic [31:0] scratch_q;
  logic [31:0] sync1_q;
  logic [31:0] sync2_q;
  logic        evt_prev_q;
  logic [31:0] count_q;
  logic [31:0] latch_q;
  logic        evt_rise;

  assign rty_o  = 1'b0;
  assign word   = adr_i[5:2];
  assign mapped = ~word[3];
  assign access = cyc_i & stb_i & ~ack_o & ~err_o;

`ifdef TISC_WB_REGS_ERR_EN
  // Unmapped accesses are refused: no side effects, dat_o untouched.
  assign commit = access & mapped;
`else
  assign commit = access;
`endif

  assign wr       = commit & we_i;
  assign rd       = commit & ~we_i;
  assign evt_rise = evt_i & ~evt_prev_q;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_data = 32'h0;
    case (word)
      W_ID:      rd_data = IDENT;
      W_VERSION: rd_data = VERSION;
      W_CTRL:    rd_data = ctrl_o;
      W_STATUS:  rd_data = sync2_q;
      W_COUNT:   rd_data = latch_q;
      W_SCRATCH: rd_data = scratch_q;
      default:   rd_data = 32'h0;
    endcase
  end

  // Handshake and read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o <= 1'b0;
      dat_o <= 32'h0;
    end else begin
      ack_o <= commit;
      if (rd) dat_o <= rd_data;
    end
  end

`ifdef TISC_WB_REGS_ERR_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_o <= 1'b0;
    else        err_o <= access & ~mapped;
  end
`else
  assign err_o = 1'b0;
`endif

  // Writable registers and pulse strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_o    <= CTRL_INIT;
      scratch_q <= 32'h0;
      pulse_o   <= '0;
    end else begin
      pulse_o <= '0;
      if (wr) begin
        case (word)
          W_CTRL:    ctrl_o    <= lane_merge(ctrl_o, dat_i, sel_i);
          W_SCRATCH: scratch_q <= lane_merge(scratch_q, dat_i, sel_i);
          W_PULSE:   pulse_o   <= dat_i[NPULSE-1:0];
          default:   ;
        endcase
      end
    end
  end

  // Status synchronizer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 32'h0;
      sync2_q <= 32'h0;
    end else begin
      sync1_q <= status_i;
      sync2_q <= sync1_q;
    end
  end

  // Event counter: a latch write captures the pre-increment value, and a
  // coincident rising edge becomes the first count of the new interval.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      evt_prev_q <= 1'b0;
      count_q    <= 32'h0;
      latch_q    <= 32'h0;
    end else begin
      evt_prev_q <= evt_i;
      if (wr && word == W_LATCH) begin
        latch_q <= count_q;
        count_q <= evt_rise ? 32'h1 : 32'h0;
      end else if (evt_rise && count_q != 32'hFFFF_FFFF) begin
        count_q <= count_q + 32'h1;
      end
    end
  end

endmodule

// File: tb/tb_tisc_wb_regs.sv
module tb_tisc_wb_regs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [5:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic [31:0] ctrl_o;
  logic [7:0]  pulse_o;
  logic [31:0] status_i = '0;
  logic        evt_i = 1'b0;

  tisc_wb_regs #(.NPULSE(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .ctrl_o(ctrl_o), .pulse_o(pulse_o),
    .status_i(status_i), .evt_i(evt_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic [7:0]  pulse;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_dat = 32'h0;

`ifdef TISC_WB_REGS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: every response cycle pops one expectation; quiet cycles must
  // show no pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (ack_o || err_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", {30'h0, ack_o, err_o}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("resp_kind", {31'h0, err_o}, {31'h0, e.err});
          chk("resp_dat", dat_o, e.dat);
          chk("resp_pulse", {24'h0, pulse_o}, {24'h0, e.pulse});
        end
      end else if (rst_i) begin
        chk("idle_pulse", {24'h0, pulse_o}, 32'h0);
      end
      chk("rty_zero", {31'h0, rty_o}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // One access, called and returning at a falling edge.
  task automatic wb(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic exp_err,
                    input logic [31:0] exp_rd, input logic [7:0] exp_pulse,
                    input bit hold = 0);
    exp_t e;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    if (!we && !exp_err) model_dat = exp_rd;
    e.err = exp_err; e.dat = model_dat; e.pulse = exp_pulse;
    sb.push_back(e);
    @(posedge clk_i); #1;
    chk("resp_latency", {30'h0, ack_o, err_o}, exp_err ? 32'h1 : 32'h2);
    if (!hold) begin cyc_i = 1'b0; stb_i = 1'b0; end
    @(posedge clk_i); #1;
    chk("resp_single", {30'h0, ack_o, err_o}, 32'h0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic evt_edges(input int n);
    for (int i = 0; i < n; i++) begin
      evt_i = 1'b1; @(negedge clk_i);
      evt_i = 1'b0; @(negedge clk_i);
    end
  endtask

  initial begin
    #12;
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_pulse", {24'h0, pulse_o}, 32'h0);
    chk("rst_ctrl", ctrl_o, 32'h0);
    @(negedge clk_i); rst_i = 1'b1; @(negedge clk_i);

    wb(0, 6'h00, 0, 4'hF, 0, 32'h54495343, 8'h00);
    wb(0, 6'h04, 0, 4'hF, 0, 32'h00010000, 8'h00, 1);  // strobe held: one ack only
    wb(0, 6'h05, 0, 4'hF, 0, 32'h00010000, 8'h00);     // low address bits ignored

    wb(1, 6'h08, 32'hDEADBEEF, 4'b0101, 0, 0, 8'h00);
    chk("ctrl_lanes", ctrl_o, 32'h00AD00EF);
    wb(0, 6'h08, 0, 4'hF, 0, 32'h00AD00EF, 8'h00);

    wb(1, 6'h00, 32'h11111111, 4'hF, 0, 0, 8'h00);     // RO write ignored
    wb(0, 6'h00, 0, 4'hF, 0, 32'h54495343, 8'h00);

    wb(1, 6'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 8'h00);
    wb(1, 6'h1C, 32'h12345678, 4'b1010, 0, 0, 8'h00);
    wb(0, 6'h1C, 0, 4'hF, 0, 32'h12FF56FF, 8'h00);

    wb(1, 6'h0C, 32'h000000A5, 4'h0, 0, 0, 8'hA5);
    wb(0, 6'h0C, 0, 4'hF, 0, 32'h0, 8'h00);

    status_i = 32'hCAFE0123;
    repeat (3) @(negedge clk_i);
    wb(0, 6'h10, 0, 4'hF, 0, 32'hCAFE0123, 8'h00);

    evt_edges(5);
    wb(1, 6'h18, 0, 4'hF, 0, 0, 8'h00);
    wb(0, 6'h14, 0, 4'hF, 0, 32'd5, 8'h00);
    wb(0, 6'h18, 0, 4'hF, 0, 32'h0, 8'h00);            // LATCH reads 0
    evt_edges(2);
    evt_i = 1'b1;                                       // rise on the latch edge
    wb(1, 6'h18, 0, 4'hF, 0, 0, 8'h00);
    evt_i = 1'b0;
    wb(0, 6'h14, 0, 4'hF, 0, 32'd2, 8'h00);
    wb(1, 6'h18, 0, 4'hF, 0, 0, 8'h00);
    wb(0, 6'h14, 0, 4'hF, 0, 32'd1, 8'h00);

    force dut.count_q = 32'hFFFFFFFE;
    #2;
    release dut.count_q;
    @(negedge clk_i);
    evt_edges(3);
    wb(1, 6'h18, 0, 4'hF, 0, 0, 8'h00);
    wb(0, 6'h14, 0, 4'hF, 0, 32'hFFFFFFFF, 8'h00);

    wb(0, 6'h24, 0, 4'hF, ERR_EN, 32'h0, 8'h00);
    wb(1, 6'h3C, 32'hFFFFFFFF, 4'hF, ERR_EN, 0, 8'h00);
    wb(0, 6'h1C, 0, 4'hF, 0, 32'h12FF56FF, 8'h00);

    // Reset asserted while a pulse write is being acknowledged.
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 6'h0C; dat_i = 32'h5A; sel_i = 4'hF;
    @(posedge clk_i); #1;
    chk("mid_ack_high", {31'h0, ack_o}, 32'h1);
    chk("mid_pulse_high", {24'h0, pulse_o}, 32'h5A);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("arst_ack", {31'h0, ack_o}, 32'h0);
    chk("arst_dat", dat_o, 32'h0);
    chk("arst_pulse", {24'h0, pulse_o}, 32'h0);
    chk("arst_ctrl", ctrl_o, 32'h0);
    model_dat = 32'h0;
    @(negedge clk_i); rst_i = 1'b1; @(negedge clk_i);
    wb(0, 6'h1C, 0, 4'hF, 0, 32'h0, 8'h00);
    wb(0, 6'h14, 0, 4'hF, 0, 32'h0, 8'h00);

    repeat (2) @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
